uartp_serial_port: RTL

Memory-mapped UART peripheral that sits directly downstream of the core's `UART_OP`/`data_to_mem` outputs and drives its `uart_data_out` input. It executes one single-cycle op per `uart_op` pulse. It buffers transmit and receive bytes in FIFOs and serialises/deserialises 8N1 frames (8 data bits, no parity, 1 stop bit) on the `tx`/`rx` pins using a programmable bit divisor.

---
 rtl/uartp_pkg.sv | 41 ++++
 rtl/uartp_fifo.sv | 53 +++++
 rtl/uartp_serial_port.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uartp_pkg.sv
// Shared types and constants for the uartp serial port.
// UARTP_PARITY_EN selects 8E1 framing instead of 8N1.
package uartp_pkg;

  typedef enum logic [1:0] {
    UOP_STATUS = 2'b00,
    UOP_PUSH   = 2'b01,
    UOP_POP    = 2'b10,
    UOP_DIV    = 2'b11
  } uop_e;

  localparam int unsigned ST_RX_VALID   = 8;
  localparam int unsigned ST_TX_FULL    = 9;
  localparam int unsigned ST_RX_OVERRUN = 10;
  localparam int unsigned ST_TX_IDLE    = 11;
  localparam int unsigned ST_FRAME_ERR  = 12;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [15:0] DIV_MIN = 16'd2;

  // A divisor below two would leave no room for the half-bit sample point.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uartp_fifo.sv
// Small register-file FIFO with combinational head; a pop on a full FIFO
// lets a same-cycle push through so the count stays unchanged.
module uartp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uartp_serial_port.sv
// Memory-mapped UART: op-driven TX/RX FIFOs around 8N1 shifters.
// Define UARTP_PARITY_EN for 8E1 frames (even parity after the data bits).
module uartp_serial_port
  import uartp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  uart_op,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rx,
  output logic        tx
);

  uop_e        op;
  logic [15:0] div_reg;
  logic        unused_data_hi;

  assign op             = uop_e'(uart_op);
  assign unused_data_hi = ^data_in[31:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_reg <= DIV_RESET;
    else if (op == UOP_DIV)  div_reg <= clamp_div(data_in[15:0]);
  end

  // ---------------- transmit ----------------
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_bit_done, tx_idle;
  logic [7:0]  tx_head;
  tx_state_e   tx_state_reg;
  logic [15:0] tx_cnt_reg, tx_div_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_reg;
`ifdef UARTP_PARITY_EN
  logic        tx_par_reg;
`endif

  assign tx_push     = (op == UOP_PUSH);
  assign tx_bit_done = (tx_cnt_reg == 16'd0);
  // Reloading straight out of the stop bit keeps queued frames gap-free.
  assign tx_pop      = !tx_empty &&
                       ((tx_state_reg == TX_IDLE) || (tx_state_reg == TX_STOP && tx_bit_done));
  assign tx_idle     = tx_empty && (tx_state_reg == TX_IDLE);
  assign tx          = tx_reg;

  uartp_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (data_in[7:0]),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_div_reg   <= DIV_MIN;
      tx_shift_reg <= 8'h00;
      tx_bit_reg   <= 3'd0;
      tx_reg       <= 1'b1;
`ifdef UARTP_PARITY_EN
      tx_par_reg   <= 1'b0;
`endif
    end else begin
      case (tx_state_reg)
        TX_IDLE: tx_reg <= 1'b1;
        TX_START: begin
          if (tx_bit_done) begin
            tx_cnt_reg   <= tx_div_reg - 16'd1;
            tx_reg       <= tx_shift_reg[0];
            tx_bit_reg   <= 3'd0;
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_done) begin
            tx_cnt_reg <= tx_div_reg - 16'd1;
            if (tx_bit_reg == 3'd7) begin
`ifdef UARTP_PARITY_EN
              tx_reg       <= tx_par_reg;
              tx_state_reg <= TX_PARITY;
`else
              tx_reg       <= 1'b1;
              tx_state_reg <= TX_STOP;
`endif
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_reg       <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
`ifdef UARTP_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_done) begin
            tx_cnt_reg   <= tx_div_reg - 16'd1;
            tx_reg       <= 1'b1;
            tx_state_reg <= TX_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_done) begin
            tx_reg       <= 1'b1;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: begin
          tx_reg       <= 1'b1;
          tx_state_reg <= TX_IDLE;
        end
      endcase
      // The divisor is captured here so a mid-frame op 11 cannot stretch bits.
      if (tx_pop) begin
        tx_state_reg <= TX_START;
        tx_div_reg   <= div_reg;
        tx_cnt_reg   <= div_reg - 16'd1;
        tx_shift_reg <= tx_head;
        tx_reg       <= 1'b0;
`ifdef UARTP_PARITY_EN
        tx_par_reg   <= ^tx_head;
`endif
      end
    end
  end

  // ---------------- receive ----------------
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic        rx_fall, rx_bit_done, rx_stop_sample, rx_good, rx_bad;
  logic        rx_pop, rx_full, rx_empty, overrun_set;
  logic [7:0]  rx_head;
  rx_state_e   rx_state_reg;
  logic [15:0] rx_cnt_reg, rx_div_reg;
  logic [7:0]  rx_shift_reg;
  logic [2:0]  rx_bit_reg;
  logic        rx_overrun_reg, frame_err_reg;
`ifdef UARTP_PARITY_EN
  logic        rx_par_err_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall        = rx_prev_reg && !rx_sync_reg;
  assign rx_bit_done    = (rx_cnt_reg == 16'd0);
  assign rx_stop_sample = (rx_state_reg == RX_STOP) && rx_bit_done;
`ifdef UARTP_PARITY_EN
  assign rx_good        = rx_stop_sample && rx_sync_reg && !rx_par_err_reg;
`else
  assign rx_good        = rx_stop_sample && rx_sync_reg;
`endif
  assign rx_bad         = rx_stop_sample && !rx_good;
  assign rx_pop         = (op == UOP_POP);
  // A pop on a full FIFO frees the slot, so only a pop-less arrival overruns.
  assign overrun_set    = rx_good && rx_full && !rx_pop;

  uartp_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_good),
    .push_data (rx_shift_reg),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= 16'd0;
      rx_div_reg   <= DIV_MIN;
      rx_shift_reg <= 8'h00;
      rx_bit_reg   <= 3'd0;
`ifdef UARTP_PARITY_EN
      rx_par_err_reg <= 1'b0;
`endif
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_div_reg   <= div_reg;
            rx_cnt_reg   <= (div_reg >> 1) - 16'd1;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_bit_done) begin
            if (rx_sync_reg) begin
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_cnt_reg   <= rx_div_reg - 16'd1;
              rx_bit_reg   <= 3'd0;
              rx_state_reg <= RX_DATA;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_bit_done) begin
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= rx_div_reg - 16'd1;
            if (rx_bit_reg == 3'd7) begin
`ifdef UARTP_PARITY_EN
              rx_state_reg <= RX_PARITY;
`else
              rx_state_reg <= RX_STOP;
`endif
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
`ifdef UARTP_PARITY_EN
        RX_PARITY: begin
          if (rx_bit_done) begin
            rx_par_err_reg <= rx_sync_reg ^ (^rx_shift_reg);
            rx_cnt_reg     <= rx_div_reg - 16'd1;
            rx_state_reg   <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_bit_done) rx_state_reg <= RX_IDLE;
          else             rx_cnt_reg   <= rx_cnt_reg - 16'd1;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // Pop clears the sticky flags; a new error in the same cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      if (rx_pop) begin
        rx_overrun_reg <= 1'b0;
        frame_err_reg  <= 1'b0;
      end
      if (overrun_set) rx_overrun_reg <= 1'b1;
      if (rx_bad)      frame_err_reg  <= 1'b1;
    end
  end

  always_comb begin
    data_out                = 32'h0000_0000;
    data_out[7:0]           = rx_empty ? 8'h00 : rx_head;
    data_out[ST_RX_VALID]   = !rx_empty;
    data_out[ST_TX_FULL]    = tx_full;
    data_out[ST_RX_OVERRUN] = rx_overrun_reg;
    data_out[ST_TX_IDLE]    = tx_idle;
    data_out[ST_FRAME_ERR]  = frame_err_reg;
  end

endmodule
